// File: rtl/board_write_arbiter.sv
// Two-port write arbiter for a 9x9 board of 2-bit cells with a row-per-cycle clear engine.
// Latency 1 for grants and writes; a clear holds off all requests for 9 cycles.
module board_write_arbiter (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [1:0]   req_in,
    input  logic [7:0]   row_in,
    input  logic [7:0]   col_in,
    input  logic [3:0]   val_in,
    input  logic         clear_in,
    output logic [1:0]   gnt_out,
    output logic [1:0]   err_out,
    output logic         busy_out,
    output logic         done_out,
    output logic [161:0] board_out
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t         state_q, state_d;
    logic [3:0]     row_cnt_q, row_cnt_d;
    logic           last_q, last_d;
    logic [161:0]   board_q, board_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [1:0]     err_q, err_d;
    logic           done_q, done_d;

    logic [1:0]     eff_req;
    logic           win;
    logic [3:0]     sel_row;
    logic [3:0]     sel_col;
    logic [1:0]     sel_val;
    logic           legal;
    logic [7:0]     cell_idx;
    logic [7:0]     row_base;

    // A requester whose grant is currently visible is masked so a held request isn't served twice.
    assign eff_req  = req_in & ~gnt_q;
    assign win      = (eff_req == 2'b11) ? ~last_q : eff_req[1];
    assign sel_row  = win ? row_in[7:4] : row_in[3:0];
    assign sel_col  = win ? col_in[7:4] : col_in[3:0];
    assign sel_val  = win ? val_in[3:2] : val_in[1:0];
    assign legal    = (sel_row <= 4'd8) && (sel_col <= 4'd8) && (sel_val != 2'b11);
    assign cell_idx = 8'(sel_row) * 8'd9 + 8'(sel_col);
    assign row_base = 8'(row_cnt_q) * 8'd18;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            row_cnt_q <= '0;
            last_q    <= 1'b1;
            board_q   <= '0;
            gnt_q     <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            last_q    <= last_d;
            board_q   <= board_d;
            gnt_q     <= gnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clear_in) state_d = S_CLEAR;
            S_CLEAR: if (row_cnt_q == 4'd8) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        row_cnt_d = row_cnt_q;
        last_d    = last_q;
        board_d   = board_q;
        gnt_d     = '0;
        err_d     = '0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_in) begin
                    row_cnt_d = '0;
                end else if (|eff_req) begin
                    gnt_d[win] = 1'b1;
                    last_d     = win;
                    if (legal) board_d[{cell_idx, 1'b0} +: 2] = sel_val;
                    else       err_d[win] = 1'b1;
                end
            end
            S_CLEAR: begin
                board_d[row_base +: 18] = '0;
                if (row_cnt_q == 4'd8) begin
                    done_d    = 1'b1;
                    row_cnt_d = '0;
                end else begin
                    row_cnt_d = row_cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign gnt_out   = gnt_q;
    assign err_out   = err_q;
    assign busy_out  = (state_q == S_CLEAR);
    assign done_out  = done_q;
    assign board_out = board_q;

endmodule

// File: doc/board_write_arbiter.md
BOARD_WRITE_ARBITER -- requirements
Module: board_write_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_in and rst_in.
REQ-002 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 req_in  input  2  write request per requester; bit i = requester i.
REQ-005 row_in  input  8  row index per requester: [3:0] for port 0, [7:4] for port 1.
REQ-006 col_in  input  8  column index per requester: same packing as row_in.
REQ-007 val_in  input  4  cell value per requester: [1:0] for port 0, [3:2] for port 1; 00 empty, 01 black, 10 white, 11 illegal.
REQ-008 clear_in  input  1  start a full-board clear.
REQ-009 gnt_out  output  2  one-cycle grant pulse per requester; at most one bit high.
REQ-010 err_out  output  2  one-cycle error pulse, concurrent with gnt_out, for a rejected write.
REQ-011 busy_out  output  1  high while a clear is in progress.
REQ-012 done_out  output  1  one-cycle pulse when a clear completes.
REQ-013 board_out  output  162  registered board; cell (r,c) occupies bits [2*(9r+c)+1 : 2*(9r+c)], so (8,8) is [161:160] and (0,0) is [1:0].

Function
REQ-014 SHALL implement states IDLE and CLEAR; the row counter selects the row being cleared in CLEAR.
REQ-015 IDLE, clear_in=1: SHALL enter CLEAR with row counter 0; pending requests are not served that cycle.
REQ-016 IDLE, clear_in=0, effective request present: SHALL serve exactly one requester per cycle.
REQ-017 Effective request i = req_in[i] AND NOT gnt_out[i]; a requester held high for the cycle its grant is visible is not re-served.
REQ-018 Arbitration: single effective request wins; if both, the port not served last wins (round-robin); the last-served pointer resets so port 0 wins the first tie.
REQ-019 Winner in cycle t: gnt_out[winner]=1 during cycle t+1; for a legal write, board_out reflects the new cell in cycle t+1 (latency 1).
REQ-020 Legal write: row<=8, col<=8, val!=11; the selected cell is overwritten (any value, including 00, onto any prior value).
REQ-021 Illegal write (row>8, col>8 or val=11): board unchanged, gnt_out[winner]=1 and err_out[winner]=1 in cycle t+1; the last-served pointer still advances.
REQ-022 CLEAR: SHALL zero the row given by the counter each cycle, counter 0..8; after row 8 is cleared, return to IDLE.
REQ-023 busy_out SHALL be high in every cycle the state is CLEAR (9 cycles); done_out SHALL pulse in the first IDLE cycle following CLEAR.
REQ-024 During CLEAR: requests SHALL receive no grant (they wait while held); clear_in SHALL be ignored.
REQ-025 First IDLE cycle after CLEAR: arbitration resumes in that same cycle; a clear_in high in that cycle starts a new clear.
REQ-026 gnt_out, err_out and done_out SHALL be registered; none may depend combinationally on inputs.

Reset
REQ-027 rst_in=1 at a clock edge SHALL force IDLE, row counter 0, last-served pointer to port 1 (port 0 wins first tie), board_out all zero, and gnt_out, err_out, busy_out, done_out all 0.
REQ-028 Reset during CLEAR SHALL abort it with no done_out pulse; reset SHALL dominate clear_in and req_in in the same cycle.

Verification
REQ-029 After reset, port 0 writes (row 2, col 3, val 01) -> next cycle gnt_out=01, err_out=00, board_out[43:42]=01, all other bits 0.
REQ-030 Both ports request legally and hold -> grants alternate 01,10,01,... with each request's cell written the cycle its grant appears.
REQ-031 Port 1 writes (row 9, col 0, val 10), then (row 0, col 0, val 11) -> gnt_out=10 and err_out=10 each time, board_out unchanged.
REQ-032 Board filled with 01, clear_in pulsed -> busy_out high 9 cycles, rows 0..8 zeroed in order, done_out pulses once, board_out=0.
REQ-033 clear_in and req_in=01 same cycle -> no grant during CLEAR; gnt_out=01 in the cycle after done_out, and the write survives.
REQ-034 rst_in asserted in 4th CLEAR cycle -> next cycle busy_out=0, done_out=0, board_out=0, a port-0/port-1 tie grants port 0.
